// File: rtl/bq_pkg.sv
// Shared constants and helpers for the biquad decimating output stage.
// Default configuration plus the derived widths the stage is built around.
package bq_pkg;

  localparam int unsigned DATAWIDTH_DEF  = 16;
  localparam int unsigned OUTWIDTH_DEF   = 8;
  localparam int unsigned DECIM_LOG2_DEF = 2;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam int unsigned N    = 1 << DECIM_LOG2_DEF;
  localparam int unsigned ACCW = DATAWIDTH_DEF + DECIM_LOG2_DEF;
  localparam int unsigned LVLW = $clog2(FIFO_DEPTH_DEF) + 1;

  // Half of the group size, so the later arithmetic shift rounds half up.
  function automatic int unsigned rnd_const(int unsigned decim_log2);
    return (decim_log2 > 0) ? (32'd1 << (decim_log2 - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/bq_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with explicit level counter.
// Head word reads as zero while empty; pop on empty is ignored.
module bq_sync_fifo
  import bq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              push_eff, pop_eff;

  always_comb begin
    empty_o  = (level_q == '0);
    full_o   = (level_q == LvlW'(DEPTH));
    pop_eff  = pop_i & ~empty_o;
    // A push into a full FIFO only lands if a slot frees in the same cycle.
    push_eff = push_i & (~full_o | pop_eff);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_eff && !pop_eff) level_d = level_q + LvlW'(1);
    if (pop_eff && !push_eff) level_d = level_q - LvlW'(1);

    rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    level_o = level_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push_eff) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bq_decim_out.sv
// Biquad output stage: averages groups of 2^DECIM_LOG2 samples, keeps the upper
// OUTWIDTH bits of the rounded mean and queues them toward a valid/ready consumer.
module bq_decim_out
  import bq_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = DATAWIDTH_DEF,
  parameter int unsigned OUTWIDTH   = OUTWIDTH_DEF,
  parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          bq_clk_i,
  input  logic                          nreset,
  input  logic                          enable_i,
  input  logic                          valid_i,
  input  logic [DATAWIDTH-1:0]          y_i,
  output logic [OUTWIDTH-1:0]           y_o,
  output logic                          y_valid_o,
  input  logic                          y_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  input  logic                          clr_ovf_i
);

  localparam int unsigned GrpN = 1 << DECIM_LOG2;
  localparam int unsigned AccW = DATAWIDTH + DECIM_LOG2;
  localparam int unsigned CntW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic signed [AccW-1:0] RndC    = AccW'(rnd_const(DECIM_LOG2));
  localparam logic        [CntW-1:0] CntLast = CntW'(GrpN - 1);

  logic signed [DATAWIDTH-1:0] y_s;
  logic signed [AccW-1:0]      acc_q, acc_d;
  logic signed [AccW-1:0]      y_ext, sum, sum_rnd;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;
  logic                        accept, push, pop, fifo_full, fifo_empty;
  logic [OUTWIDTH-1:0]         word;
  logic                        unused_lsb;

  always_comb begin
    y_s     = y_i;
    y_ext   = AccW'(y_s);
    sum     = acc_q + y_ext;
    // Group sums never exceed AccW signed range, even with the rounding term.
    sum_rnd = sum + RndC;
    // Upper OUTWIDTH bits of (sum_rnd >>> DECIM_LOG2), taken without shifting.
    word    = sum_rnd[DATAWIDTH+DECIM_LOG2-1 -: OUTWIDTH];

    accept = enable_i & valid_i;
    push   = accept & (cnt_q == CntLast);
    pop    = y_valid_o & y_ready_i;

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (!enable_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (push) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + CntW'(1);
    end

    ovf_d = ovf_q;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    else if (clr_ovf_i)            ovf_d = 1'b0;
  end

  assign unused_lsb = ^sum_rnd[DATAWIDTH+DECIM_LOG2-OUTWIDTH-1:0];

  always_ff @(posedge bq_clk_i) begin
    if (!nreset) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  bq_sync_fifo #(
    .DATA_W (OUTWIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (bq_clk_i),
    .rst_ni  (nreset),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (pop),
    .rdata_o (y_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign y_valid_o  = ~fifo_empty;
  assign overflow_o = ovf_q;

endmodule
